// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU width and SELECT opcode constants
package alu_pkg;

    localparam int DATA_W = 32;

    // Base integer operations
    localparam logic [5:0] OP_ADD    = 6'b000000;
    localparam logic [5:0] OP_SLL    = 6'b000001;
    localparam logic [5:0] OP_SLT    = 6'b000010;
    localparam logic [5:0] OP_SLTU   = 6'b000011;
    localparam logic [5:0] OP_XOR    = 6'b000100;
    localparam logic [5:0] OP_SRL    = 6'b000101;
    localparam logic [5:0] OP_OR     = 6'b000110;
    localparam logic [5:0] OP_AND    = 6'b000111;
    localparam logic [5:0] OP_SUB    = 6'b010000;
    localparam logic [5:0] OP_SRA    = 6'b010101;
    localparam logic [5:0] OP_FWD    = 6'b011111;

    // Multiply/divide operations; the low three bits select the muldiv function
    localparam logic [5:0] OP_MUL    = 6'b001000;
    localparam logic [5:0] OP_MULH   = 6'b001001;
    localparam logic [5:0] OP_MULHSU = 6'b001010;
    localparam logic [5:0] OP_MULHU  = 6'b001011;
    localparam logic [5:0] OP_DIV    = 6'b001100;
    localparam logic [5:0] OP_DIVU   = 6'b001101;
    localparam logic [5:0] OP_REM    = 6'b001110;
    localparam logic [5:0] OP_REMU   = 6'b001111;

endpackage

// File: rtl/alu_muldiv.sv
// rtl/alu_muldiv.sv - combinational multiply/divide unit for the ALU
// Ports: a, b (operands), funct (SELECT[2:0]: MUL MULH MULHSU MULHU DIV DIVU REM REMU), y (result)
module alu_muldiv
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [2:0]        funct,
    output logic [DATA_W-1:0] y
);

    logic [63:0] a_sx, a_zx, b_sx, b_zx;
    logic [63:0] prod_ss, prod_su, prod_uu;
    logic        div_zero, div_ovf;
    logic [DATA_W-1:0] quot_s, rem_s, quot_u, rem_u;

    // Products are taken modulo 2^64 on extended operands, which gives the
    // correct high word for each signedness combination.
    assign a_sx = {{32{a[31]}}, a};
    assign a_zx = {32'b0, a};
    assign b_sx = {{32{b[31]}}, b};
    assign b_zx = {32'b0, b};

    assign prod_ss = a_sx * b_sx;
    assign prod_su = a_sx * b_zx;
    assign prod_uu = a_zx * b_zx;

    assign div_zero = (b == '0);
    assign div_ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

    always_comb begin
        quot_s = '0;
        rem_s  = '0;
        quot_u = '0;
        rem_u  = '0;
        // Zero-divisor and overflow cases are resolved explicitly rather than
        // relying on the divider's behaviour for those operands.
        if (div_zero) begin
            quot_s = 32'hFFFF_FFFF;
            quot_u = 32'hFFFF_FFFF;
            rem_s  = a;
            rem_u  = a;
        end else if (div_ovf) begin
            quot_s = 32'h8000_0000;
            rem_s  = '0;
            quot_u = a / b;
            rem_u  = a % b;
        end else begin
            quot_s = $signed(a) / $signed(b);
            rem_s  = $signed(a) % $signed(b);
            quot_u = a / b;
            rem_u  = a % b;
        end
    end

    always_comb begin
        y = '0;
        case (funct)
            3'b000:  y = prod_uu[31:0];
            3'b001:  y = prod_ss[63:32];
            3'b010:  y = prod_su[63:32];
            3'b011:  y = prod_uu[63:32];
            3'b100:  y = quot_s;
            3'b101:  y = quot_u;
            3'b110:  y = rem_s;
            default: y = rem_u;
        endcase
    end

endmodule

// File: rtl/alu.sv
// rtl/alu.sv - 32-bit ALU with one-cycle registered result; ALU_M_EXT_EN adds multiply/divide
// Ports: CLK, RESET_N (sync active-low), DATA1 (operand A), DATA2 (operand B), SELECT (opcode), RESULT (registered)
module alu
    import alu_pkg::*;
(
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic [DATA_W-1:0] DATA1,
    input  logic [DATA_W-1:0] DATA2,
    input  logic [5:0]        SELECT,
    output logic [DATA_W-1:0] RESULT
);

    logic [DATA_W-1:0] result_d, result_q;
    logic [4:0]        shamt;

    assign shamt = DATA2[4:0];

`ifdef ALU_M_EXT_EN
    logic [DATA_W-1:0] muldiv_y;

    alu_muldiv u_muldiv (
        .a     (DATA1),
        .b     (DATA2),
        .funct (SELECT[2:0]),
        .y     (muldiv_y)
    );
`endif

    always_comb begin
        result_d = '0;
        case (SELECT)
            OP_ADD:  result_d = DATA1 + DATA2;
            OP_SUB:  result_d = DATA1 - DATA2;
            OP_SLL:  result_d = DATA1 << shamt;
            OP_SLT:  result_d = {31'b0, ($signed(DATA1) < $signed(DATA2))};
            OP_SLTU: result_d = {31'b0, (DATA1 < DATA2)};
            OP_XOR:  result_d = DATA1 ^ DATA2;
            OP_OR:   result_d = DATA1 | DATA2;
            OP_AND:  result_d = DATA1 & DATA2;
            OP_SRL:  result_d = DATA1 >> shamt;
            OP_SRA:  result_d = $signed(DATA1) >>> shamt;
            OP_FWD:  result_d = DATA2;
`ifdef ALU_M_EXT_EN
            OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
            OP_DIV, OP_DIVU, OP_REM, OP_REMU:
                     result_d = muldiv_y;
`endif
            default: result_d = '0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            result_q <= '0;
        end else begin
            result_q <= result_d;
        end
    end

    assign RESULT = result_q;

endmodule

// File: tb/tb_alu.sv
// tb/tb_alu.sv - directed self-checking bench for alu
module tb_alu;
    import alu_pkg::*;

    logic              clk;
    logic              reset_n;
    logic [DATA_W-1:0] data1;
    logic [DATA_W-1:0] data2;
    logic [5:0]        sel;
    logic [DATA_W-1:0] result;

    int pass_cnt;
    int total_cnt;

    alu dut (
        .CLK     (clk),
        .RESET_N (reset_n),
        .DATA1   (data1),
        .DATA2   (data2),
        .SELECT  (sel),
        .RESULT  (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        if (obs === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Apply inputs away from the edge, clock once, sample 1 time unit later.
    task automatic op(input string tag, input logic [5:0] s, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] exp);
        @(negedge clk);
        sel   = s;
        data1 = a;
        data2 = b;
        @(posedge clk);
        #1;
        chk(tag, result, exp);
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        reset_n   = 1'b0;
        sel       = OP_ADD;
        data1     = 32'd2;
        data2     = 32'd3;

        // Reset overrides the ADD presented in the same cycle
        @(posedge clk);
        #1;
        chk("reset", result, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // Operand sweep with DATA1=2, DATA2=3
        op("add",  OP_ADD,  32'd2, 32'd3, 32'd5);
        op("sll",  OP_SLL,  32'd2, 32'd3, 32'd16);
        op("slt",  OP_SLT,  32'd2, 32'd3, 32'd1);
        op("sltu", OP_SLTU, 32'd2, 32'd3, 32'd1);
        op("xor",  OP_XOR,  32'd2, 32'd3, 32'd1);
        op("srl",  OP_SRL,  32'd2, 32'd3, 32'd0);
        op("or",   OP_OR,   32'd2, 32'd3, 32'd3);
        op("and",  OP_AND,  32'd2, 32'd3, 32'd2);
        op("sub",  OP_SUB,  32'd2, 32'd3, 32'hFFFF_FFFF);
        op("sra",  OP_SRA,  32'd2, 32'd3, 32'd0);
        op("fwd",  OP_FWD,  32'd2, 32'd3, 32'd3);

        // Signed and shift edges
        op("sra_neg",   OP_SRA,  32'h8000_0000, 32'd4, 32'hF800_0000);
        op("srl_neg",   OP_SRL,  32'h8000_0000, 32'd4, 32'h0800_0000);
        op("slt_neg",   OP_SLT,  32'hFFFF_FFFF, 32'd1, 32'd1);
        op("sltu_big",  OP_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0);
        op("sll_mask",  OP_SLL,  32'd1, 32'h25, 32'h20);
        op("srl_mask",  OP_SRL,  32'h8000_0000, 32'h25, 32'h0400_0000);
        op("add_wrap",  OP_ADD,  32'hFFFF_FFFF, 32'd2, 32'd1);

        // Undefined codes
        op("undef_3f",  6'b111111, 32'd2, 32'd3, 32'd0);
        op("undef_11",  6'b010001, 32'd2, 32'd3, 32'd0);

`ifdef ALU_M_EXT_EN
        op("mul",     OP_MUL,    32'd2, 32'd3, 32'd6);
        op("mulh",    OP_MULH,   32'd2, 32'd3, 32'd0);
        op("mulhsu",  OP_MULHSU, 32'd2, 32'd3, 32'd0);
        op("mulhu",   OP_MULHU,  32'd2, 32'd3, 32'd0);
        op("div",     OP_DIV,    32'd2, 32'd3, 32'd0);
        op("divu",    OP_DIVU,   32'd2, 32'd3, 32'd0);
        op("rem",     OP_REM,    32'd2, 32'd3, 32'd2);
        op("remu",    OP_REMU,   32'd2, 32'd3, 32'd2);
        op("mulh_m1",   OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0);
        op("mulhu_m1",  OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        op("mulhsu_m1", OP_MULHSU, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFF);
        op("div_neg",   OP_DIV,    32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        op("rem_neg",   OP_REM,    32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        op("div_z",   OP_DIV,    32'd7, 32'd0, 32'hFFFF_FFFF);
        op("divu_z",  OP_DIVU,   32'd7, 32'd0, 32'hFFFF_FFFF);
        op("rem_z",   OP_REM,    32'd7, 32'd0, 32'd7);
        op("remu_z",  OP_REMU,   32'd7, 32'd0, 32'd7);
        op("div_ovf", OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        op("rem_ovf", OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
`else
        op("mul_off",  OP_MUL,  32'd2, 32'd3, 32'd0);
        op("div_off",  OP_DIV,  32'd7, 32'd0, 32'd0);
        op("remu_off", OP_REMU, 32'd7, 32'd2, 32'd0);
`endif

        // Mid-stream reset, then first edge after release is valid
        op("pre_rst", OP_FWD, 32'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        @(negedge clk);
        reset_n = 1'b0;
        sel     = OP_FWD;
        data2   = 32'h5555_5555;
        @(posedge clk);
        #1;
        chk("reset_mid", result, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        op("post_rst", OP_FWD, 32'd0, 32'h0000_1234, 32'h0000_1234);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
